keypad_time_loader: RTL

Sits directly downstream of the keypad block. It consumes the 4-digit BCD entry buffer (keypad_values) and the digit-shifted strobe (shift_pulse), and sequences a user "set time" or "set alarm" entry. Once four digits are entered it validates them as 24-hour HH:MM. A valid entry is committed to the clock counter or the alarm register with a one-cycle load strobe. It also drives the keypad's reset_shift input to blank the entry buffer at the start and end of every entry.

---
 rtl/keypad_time_loader_if.sv | 35 +++
 rtl/keypad_time_loader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/keypad_time_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_time_loader_if
// Description : Keypad entry / load bundle between the keypad front end,
//               the time loader and the clock/alarm registers.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_time_loader_if;
   logic [15:0] keypad_values;
   logic        shift_pulse;
   logic        set_time_btn;
   logic        set_alarm_btn;
   logic        clear_entry;
   logic [15:0] load_value;
   logic        load_time;
   logic        load_alarm;
   logic        entry_active;
   logic        entry_error;
   logic [2:0]  digit_count;

   // Driver side: keypad + buttons, observes the loader outputs
   modport master (
      output keypad_values, shift_pulse, set_time_btn, set_alarm_btn,
      input  clear_entry, load_value, load_time, load_alarm,
             entry_active, entry_error, digit_count
   );

   // Loader side
   modport slave (
      input  keypad_values, shift_pulse, set_time_btn, set_alarm_btn,
      output clear_entry, load_value, load_time, load_alarm,
             entry_active, entry_error, digit_count
   );
endinterface
`default_nettype wire

// File: rtl/keypad_time_loader.sv
`default_nettype none
// ============================================================================
// Module      : keypad_time_loader
// Description : Sequences a "set time" / "set alarm" keypad entry, validates
//               the four BCD digits as 24-hour HH:MM and commits them with a
//               one-cycle load strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_time_loader #(
   parameter int TIMEOUT_CYCLES  = 1000,
   parameter int ERR_HOLD_CYCLES = 8
) (
   input  wire                   clk,
   input  wire                   reset,
   keypad_time_loader_if.slave   bus
);

   localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int c_ERR_W = $clog2(ERR_HOLD_CYCLES + 1);
   localparam logic [c_TMO_W-1:0] c_TMO_LAST   = c_TMO_W'(TIMEOUT_CYCLES);
   localparam logic [c_ERR_W-1:0] c_ERR_RELOAD = c_ERR_W'(ERR_HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ENTRY    = 3'd1,
      S_VALIDATE = 3'd2,
      S_COMMIT   = 3'd3,
      S_ERROR    = 3'd4
   } state_t;

   state_t              r_state;
   logic [2:0]          r_sync_a;
   logic [2:0]          r_sync_b;
   logic [2:0]          r_prev;
   logic [c_TMO_W-1:0]  r_tmo;
   logic [c_ERR_W-1:0]  r_err_cnt;
   logic                r_target_alarm;
   logic                r_clear_entry;
   logic [15:0]         r_load_value;
   logic                r_load_time;
   logic                r_load_alarm;
   logic                r_entry_active;
   logic                r_entry_error;
   logic [2:0]          r_digit_count;

   logic [2:0]          w_edge;
   logic                w_shift_edge;
   logic                w_time_edge;
   logic                w_alarm_edge;
   logic [3:0]          w_h1, w_h0, w_m1, w_m0;
   logic                w_valid;

   // Bit order in the synchroniser vectors: {set_alarm, set_time, shift}
   assign w_edge       = r_sync_b & ~r_prev;
   assign w_shift_edge = w_edge[0];
   assign w_time_edge  = w_edge[1];
   assign w_alarm_edge = w_edge[2];

   // HH:MM check on the BCD buffer; hours tens <= 2 also covers the <= 9 rule
   assign w_h1    = bus.keypad_values[15:12];
   assign w_h0    = bus.keypad_values[11:8];
   assign w_m1    = bus.keypad_values[7:4];
   assign w_m0    = bus.keypad_values[3:0];
   assign w_valid = (w_h1 <= 4'd2) && (w_h0 <= 4'd9) && (w_m1 <= 4'd5) &&
                    (w_m0 <= 4'd9) && !((w_h1 == 4'd2) && (w_h0 > 4'd3));

   assign bus.clear_entry  = r_clear_entry;
   assign bus.load_value   = r_load_value;
   assign bus.load_time    = r_load_time;
   assign bus.load_alarm   = r_load_alarm;
   assign bus.entry_active = r_entry_active;
   assign bus.entry_error  = r_entry_error;
   assign bus.digit_count  = r_digit_count;

   // Two-flop synchronisers plus previous-value register for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync_a <= 3'b000;
         r_sync_b <= 3'b000;
         r_prev   <= 3'b000;
      end else begin
         r_sync_a <= {bus.set_alarm_btn, bus.set_time_btn, bus.shift_pulse};
         r_sync_b <= r_sync_a;
         r_prev   <= r_sync_b;
      end
   end

   // Entry sequencer; all outputs are registered and set on the transition
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_tmo          <= '0;
         r_err_cnt      <= '0;
         r_target_alarm <= 1'b0;
         r_clear_entry  <= 1'b0;
         r_load_value   <= 16'h0000;
         r_load_time    <= 1'b0;
         r_load_alarm   <= 1'b0;
         r_entry_active <= 1'b0;
         r_entry_error  <= 1'b0;
         r_digit_count  <= 3'd0;
      end else begin
         r_clear_entry <= 1'b0;
         r_load_time   <= 1'b0;
         r_load_alarm  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_time_edge || w_alarm_edge) begin
                  r_target_alarm <= !w_time_edge;
                  r_clear_entry  <= 1'b1;
                  r_digit_count  <= 3'd0;
                  r_tmo          <= '0;
                  r_entry_active <= 1'b1;
                  r_state        <= S_ENTRY;
               end
            end
            S_ENTRY: begin
               if (w_time_edge || w_alarm_edge) begin
                  // A new button press restarts the entry and wins over a digit
                  r_target_alarm <= !w_time_edge;
                  r_clear_entry  <= 1'b1;
                  r_digit_count  <= 3'd0;
                  r_tmo          <= '0;
               end else if (w_shift_edge) begin
                  r_digit_count <= r_digit_count + 3'd1;
                  r_tmo         <= '0;
                  if (r_digit_count == 3'd3) begin
                     r_state <= S_VALIDATE;
                  end
               end else if (r_tmo == c_TMO_LAST) begin
                  // Abandoned entry: blank the buffer silently
                  r_clear_entry  <= 1'b1;
                  r_digit_count  <= 3'd0;
                  r_entry_active <= 1'b0;
                  r_state        <= S_IDLE;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            S_VALIDATE: begin
               r_clear_entry  <= 1'b1;
               r_digit_count  <= 3'd0;
               r_entry_active <= 1'b0;
               if (w_valid) begin
                  r_load_value <= bus.keypad_values;
                  r_load_time  <= !r_target_alarm;
                  r_load_alarm <= r_target_alarm;
                  r_state      <= S_COMMIT;
               end else begin
                  r_entry_error <= 1'b1;
                  r_err_cnt     <= c_ERR_RELOAD;
                  r_state       <= S_ERROR;
               end
            end
            S_COMMIT: begin
               r_state <= S_IDLE;
            end
            S_ERROR: begin
               // Button edges are deliberately ignored while the error is shown
               if (r_err_cnt == '0) begin
                  r_entry_error <= 1'b0;
                  r_state       <= S_IDLE;
               end else begin
                  r_err_cnt <= r_err_cnt - 1'b1;
               end
            end
            default: begin
               r_entry_active <= 1'b0;
               r_entry_error  <= 1'b0;
               r_digit_count  <= 3'd0;
               r_state        <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
